pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl_pkg.sv | 34 +++
 rtl/pwm_ramp_step.sv | 49 ++++
 rtl/pwm_ramp_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl_pkg
// Description : Shared constants for the PWM duty ramp controller: register
//               indices, CTRL bit positions and the ramp FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ramp_ctrl_pkg;

    // Word register indices on the bus
    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PERIOD = 2'd1;
    localparam logic [1:0] c_REG_TARGET = 2'd2;
    localparam logic [1:0] c_REG_STEP   = 2'd3;

    // CTRL register bit positions
    localparam int c_CTRL_EN    = 0;
    localparam int c_CTRL_START = 1;
    localparam int c_CTRL_IE    = 2;
    localparam int c_CTRL_DONE  = 3;
    localparam int c_CTRL_BUSY  = 4;

    // Least significant bit of the prescale field inside STEP
    localparam int c_STEP_PRESC_LSB = 16;

    // Ramp sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } ramp_state_e;

endpackage : pwm_ramp_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_ramp_step.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_step
// Description : Combinational next-duty computation. Moves the current duty
//               one step toward the target (clamped to the period), landing
//               exactly on the clamped target instead of overshooting.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_step
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic [CNT_W-1:0] i_current,
    input  logic [CNT_W-1:0] i_target,
    input  logic [CNT_W-1:0] i_step,
    input  logic [CNT_W-1:0] i_period,
    output logic [CNT_W-1:0] o_next,
    output logic             o_reached
);

    // One extra bit of headroom so current+step can never wrap
    logic [CNT_W:0] w_cur;
    logic [CNT_W:0] w_step;
    logic [CNT_W:0] w_clamped;
    logic [CNT_W:0] w_gap;
    logic [CNT_W:0] w_next;

    // Step toward the clamped target; a zero step or a gap no larger than the
    // step lands directly on the target, so both directions saturate cleanly.
    always_comb begin
        w_cur     = {1'b0, i_current};
        w_step    = {1'b0, i_step};
        w_clamped = (i_target > i_period) ? {1'b0, i_period} : {1'b0, i_target};
        w_gap     = (w_cur > w_clamped) ? (w_cur - w_clamped) : (w_clamped - w_cur);
        w_next    = w_clamped;
        if ((i_step != '0) && (w_gap > w_step)) begin
            if (w_cur < w_clamped) begin
                w_next = w_cur + w_step;
            end else begin
                w_next = w_cur - w_step;
            end
        end
        o_next    = w_next[CNT_W-1:0];
        o_reached = (w_next == w_clamped);
    end

endmodule : pwm_ramp_step
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : Bus-programmable duty-cycle ramp generator for a PWM core.
//               Steps the duty toward a target once every (prescale+1) PWM
//               periods and hands period/duty to the core with a load pulse
//               right after each period wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    input  logic             i_period_end,
    output logic [CNT_W-1:0] o_pwm_period,
    output logic [CNT_W-1:0] o_pwm_duty,
    output logic             o_pwm_load,
    output logic             o_irq
);

    // Programmable registers
    logic               r_en;
    logic               r_ie;
    logic               r_done;
    logic [CNT_W-1:0]   r_period_shadow;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_step;
    logic [PRESC_W-1:0] r_presc;

    // Sequencer and core-facing state
    ramp_state_e        r_state;
    ramp_state_e        w_state_nxt;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_pwm_period;
    logic [CNT_W-1:0]   r_pwm_duty;
    logic               r_pwm_load;
    logic [31:0]        r_rdata;

    logic               w_wr;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_disable;
    logic               w_step_due;
    logic               w_set_done;
    logic [CNT_W-1:0]   w_step_next;
    logic               w_reached;
    logic [CNT_W-1:0]   w_duty_nxt;
    logic [31:0]        w_rd_val;
    logic               w_unused;

    assign w_wr       = i_sel & i_we;
    assign w_ctrl_wr  = w_wr & (i_addr == c_REG_CTRL);
    assign w_start    = w_ctrl_wr & i_wdata[c_CTRL_START] & i_wdata[c_CTRL_EN];
    assign w_disable  = w_ctrl_wr & ~i_wdata[c_CTRL_EN];
    assign w_step_due = (r_state == ST_RAMP) & i_period_end & (r_presc_cnt == r_presc);
    assign w_set_done = w_step_due & w_reached;
    assign w_unused   = ^i_wdata;

    // Clamping uses the period that is applied alongside the new duty
    pwm_ramp_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .i_current (r_pwm_duty),
        .i_target  (r_target),
        .i_step    (r_step),
        .i_period  (r_period_shadow),
        .o_next    (w_step_next),
        .o_reached (w_reached)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next duty; disable outranks START, START outranks completion
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_pwm_duty;
        case (r_state)
            ST_IDLE: if (i_period_end && !r_en) w_duty_nxt = '0;
            ST_RAMP: if (w_step_due)            w_duty_nxt = w_step_next;
            default: ;
        endcase
        if (w_set_done) w_state_nxt = ST_HOLD;
        if (w_start)    w_state_nxt = ST_RAMP;
        if (w_disable)  w_state_nxt = ST_IDLE;
    end

    // Bus-writable registers; values sampled by a coincident period_end are the old ones
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_en            <= 1'b0;
            r_ie            <= 1'b0;
            r_period_shadow <= '0;
            r_target        <= '0;
            r_step          <= '0;
            r_presc         <= '0;
        end else if (w_wr) begin
            case (i_addr)
                c_REG_CTRL: begin
                    r_en <= i_wdata[c_CTRL_EN];
                    r_ie <= i_wdata[c_CTRL_IE];
                end
                c_REG_PERIOD: r_period_shadow <= i_wdata[CNT_W-1:0];
                c_REG_TARGET: r_target        <= i_wdata[CNT_W-1:0];
                default: begin
                    r_step  <= i_wdata[CNT_W-1:0];
                    r_presc <= i_wdata[c_STEP_PRESC_LSB +: PRESC_W];
                end
            endcase
        end
    end

    // DONE flag: completion wins over a simultaneous write-1-to-clear
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_done <= 1'b0;
        end else if (w_set_done) begin
            r_done <= 1'b1;
        end else if (w_ctrl_wr && i_wdata[c_CTRL_DONE]) begin
            r_done <= 1'b0;
        end
    end

    // Prescaler counts period wraps while ramping; START restarts it
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_presc_cnt <= '0;
        end else if (w_start) begin
            r_presc_cnt <= '0;
        end else if ((r_state == ST_RAMP) && i_period_end) begin
            r_presc_cnt <= (r_presc_cnt == r_presc) ? '0 : r_presc_cnt + 1'b1;
        end
    end

    // Core outputs update only at a period wrap, with a load pulse when anything changes
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pwm_period <= '0;
            r_pwm_duty   <= '0;
            r_pwm_load   <= 1'b0;
        end else if (i_period_end) begin
            r_pwm_period <= r_period_shadow;
            r_pwm_duty   <= w_duty_nxt;
            r_pwm_load   <= (r_period_shadow != r_pwm_period) || (w_duty_nxt != r_pwm_duty);
        end else begin
            r_pwm_load   <= 1'b0;
        end
    end

    // Read mux for the addressed register, unused bits zero
    always_comb begin
        w_rd_val = '0;
        case (i_addr)
            c_REG_CTRL: begin
                w_rd_val[c_CTRL_EN]   = r_en;
                w_rd_val[c_CTRL_IE]   = r_ie;
                w_rd_val[c_CTRL_DONE] = r_done;
                w_rd_val[c_CTRL_BUSY] = (r_state == ST_RAMP);
            end
            c_REG_PERIOD: w_rd_val[CNT_W-1:0] = r_period_shadow;
            c_REG_TARGET: w_rd_val[CNT_W-1:0] = r_target;
            default: begin
                w_rd_val[CNT_W-1:0]                    = r_step;
                w_rd_val[c_STEP_PRESC_LSB +: PRESC_W] = r_presc;
            end
        endcase
    end

    // Registered read data, captured whenever the block is selected
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rdata <= '0;
        end else if (i_sel) begin
            r_rdata <= w_rd_val;
        end
    end

    assign o_rdata      = r_rdata;
    assign o_pwm_period = r_pwm_period;
    assign o_pwm_duty   = r_pwm_duty;
    assign o_pwm_load   = r_pwm_load;
    assign o_irq        = r_done & r_ie;

endmodule : pwm_ramp_ctrl
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ramp_ctrl
// Description : Directed, table-driven bench for pwm_ramp_ctrl. Each vector
//               is one clock cycle of bus/period_end stimulus with the
//               hand-computed outputs expected just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    localparam logic [1:0] A_CTL = 2'd0;
    localparam logic [1:0] A_PER = 2'd1;
    localparam logic [1:0] A_TGT = 2'd2;
    localparam logic [1:0] A_STP = 2'd3;

    logic        CLK;
    logic        RESETN;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        period_end;
    logic [15:0] pwm_period;
    logic [15:0] pwm_duty;
    logic        pwm_load;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        pe;
        logic [15:0] e_period;
        logic [15:0] e_duty;
        logic        e_load;
        logic        e_irq;
        logic        chk_rd;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];
    vec_t vr[$];

    pwm_ramp_ctrl #(
        .CNT_W   (16),
        .PRESC_W (8)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .i_sel        (sel),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .i_period_end (period_end),
        .o_pwm_period (pwm_period),
        .o_pwm_duty   (pwm_duty),
        .o_pwm_load   (pwm_load),
        .o_irq        (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, input logic w, input logic [1:0] a,
                                input logic [31:0] d, input logic pe,
                                input logic [15:0] ep, input logic [15:0] ed,
                                input logic el, input logic ei,
                                input logic cr, input logic [31:0] er);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.wdata = d; v.pe = pe;
        v.e_period = ep; v.e_duty = ed; v.e_load = el; v.e_irq = ei;
        v.chk_rd = cr; v.e_rdata = er;
        return v;
    endfunction

    // Write, write with coincident period_end, period_end, read, idle
    function automatic vec_t W(input logic [1:0] a, input logic [31:0] d,
                               input logic [15:0] ep, input logic [15:0] ed, input logic ei);
        return mk(1'b1, 1'b1, a, d, 1'b0, ep, ed, 1'b0, ei, 1'b0, 32'd0);
    endfunction
    function automatic vec_t WP(input logic [1:0] a, input logic [31:0] d,
                                input logic [15:0] ep, input logic [15:0] ed,
                                input logic el, input logic ei);
        return mk(1'b1, 1'b1, a, d, 1'b1, ep, ed, el, ei, 1'b0, 32'd0);
    endfunction
    function automatic vec_t P(input logic [15:0] ep, input logic [15:0] ed,
                               input logic el, input logic ei);
        return mk(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, ep, ed, el, ei, 1'b0, 32'd0);
    endfunction
    function automatic vec_t R(input logic [1:0] a, input logic [31:0] er,
                               input logic [15:0] ep, input logic [15:0] ed, input logic ei);
        return mk(1'b1, 1'b0, a, 32'd0, 1'b0, ep, ed, 1'b0, ei, 1'b1, er);
    endfunction
    function automatic vec_t N(input logic [15:0] ep, input logic [15:0] ed, input logic ei);
        return mk(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, ep, ed, 1'b0, ei, 1'b0, 32'd0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge CLK);
        sel = v.sel; we = v.we; addr = v.addr; wdata = v.wdata; period_end = v.pe;
        @(posedge CLK);
        #2;
        chk("pwm_period", idx, 32'(pwm_period), 32'(v.e_period));
        chk("pwm_duty",   idx, 32'(pwm_duty),   32'(v.e_duty));
        chk("pwm_load",   idx, 32'(pwm_load),   32'(v.e_load));
        chk("irq",        idx, 32'(irq),        32'(v.e_irq));
        if (v.chk_rd) chk("rdata", idx, rdata, v.e_rdata);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " pwm_period"}, -1, 32'(pwm_period), 32'd0);
        chk({nm, " pwm_duty"},   -1, 32'(pwm_duty),   32'd0);
        chk({nm, " pwm_load"},   -1, 32'(pwm_load),   32'd0);
        chk({nm, " irq"},        -1, 32'(irq),        32'd0);
        chk({nm, " rdata"},      -1, rdata,           32'd0);
    endtask

    initial begin
        // Upward ramp 10..40, DONE and irq with IE
        vq.push_back(W(A_PER, 100, 0, 0, 0));
        vq.push_back(W(A_TGT, 40, 0, 0, 0));
        vq.push_back(W(A_STP, 10, 0, 0, 0));
        vq.push_back(W(A_CTL, 32'h07, 0, 0, 0));
        vq.push_back(R(A_CTL, 32'h15, 0, 0, 0));
        vq.push_back(P(100, 10, 1, 0)); vq.push_back(N(100, 10, 0));
        vq.push_back(P(100, 20, 1, 0)); vq.push_back(N(100, 20, 0));
        vq.push_back(P(100, 30, 1, 0)); vq.push_back(N(100, 30, 0));
        vq.push_back(P(100, 40, 1, 1));
        vq.push_back(R(A_CTL, 32'h0D, 100, 40, 1));
        vq.push_back(P(100, 40, 0, 1));
        // Downward ramp 40 -> 5, last step lands exactly on target
        vq.push_back(W(A_CTL, 32'h0D, 100, 40, 0));
        vq.push_back(W(A_TGT, 5, 100, 40, 0));
        vq.push_back(W(A_CTL, 32'h07, 100, 40, 0));
        vq.push_back(P(100, 30, 1, 0)); vq.push_back(N(100, 30, 0));
        vq.push_back(P(100, 20, 1, 0)); vq.push_back(N(100, 20, 0));
        vq.push_back(P(100, 10, 1, 0)); vq.push_back(N(100, 10, 0));
        vq.push_back(P(100, 5, 1, 1));
        // Target above period clamps to period
        vq.push_back(W(A_CTL, 32'h08, 100, 5, 0));
        vq.push_back(P(100, 0, 1, 0));
        vq.push_back(W(A_TGT, 150, 100, 0, 0));
        vq.push_back(W(A_STP, 60, 100, 0, 0));
        vq.push_back(W(A_CTL, 32'h07, 100, 0, 0));
        vq.push_back(P(100, 60, 1, 0)); vq.push_back(N(100, 60, 0));
        vq.push_back(P(100, 100, 1, 1)); vq.push_back(N(100, 100, 1));
        vq.push_back(P(100, 100, 0, 1));
        vq.push_back(R(A_CTL, 32'h0D, 100, 100, 1));
        // Prescale 2: one step every third period_end
        vq.push_back(W(A_CTL, 32'h08, 100, 100, 0));
        vq.push_back(P(100, 0, 1, 0));
        vq.push_back(W(A_TGT, 10, 100, 0, 0));
        vq.push_back(W(A_STP, 32'h0002_0001, 100, 0, 0));
        vq.push_back(W(A_CTL, 32'h07, 100, 0, 0));
        vq.push_back(P(100, 0, 0, 0)); vq.push_back(N(100, 0, 0));
        vq.push_back(P(100, 0, 0, 0)); vq.push_back(N(100, 0, 0));
        vq.push_back(P(100, 1, 1, 0)); vq.push_back(N(100, 1, 0));
        vq.push_back(P(100, 1, 0, 0)); vq.push_back(N(100, 1, 0));
        vq.push_back(P(100, 1, 0, 0)); vq.push_back(N(100, 1, 0));
        vq.push_back(P(100, 2, 1, 0));
        vq.push_back(R(A_STP, 32'h0002_0001, 100, 2, 0));
        // PERIOD write coincident with period_end applies one wrap later
        vq.push_back(WP(A_PER, 50, 100, 2, 0, 0));
        vq.push_back(N(100, 2, 0));
        vq.push_back(P(50, 2, 1, 0));
        vq.push_back(R(A_PER, 50, 50, 2, 0));
        // EN=0 mid-ramp: IDLE at once, duty 0 at next wrap
        vq.push_back(W(A_CTL, 32'h00, 50, 2, 0));
        vq.push_back(R(A_CTL, 32'h00, 50, 2, 0));
        vq.push_back(P(50, 0, 1, 0));
        vq.push_back(P(50, 0, 0, 0));
        // DONE clear coincident with reaching target: DONE stays set
        vq.push_back(W(A_TGT, 10, 50, 0, 0));
        vq.push_back(W(A_STP, 10, 50, 0, 0));
        vq.push_back(W(A_CTL, 32'h07, 50, 0, 0));
        vq.push_back(WP(A_CTL, 32'h0D, 50, 10, 1, 1));
        vq.push_back(R(A_CTL, 32'h0D, 50, 10, 1));
        vq.push_back(W(A_CTL, 32'h0D, 50, 10, 0));
        // START in HOLD, then START in RAMP toward a new target
        vq.push_back(W(A_TGT, 30, 50, 10, 0));
        vq.push_back(W(A_CTL, 32'h07, 50, 10, 0));
        vq.push_back(R(A_CTL, 32'h15, 50, 10, 0));
        vq.push_back(P(50, 20, 1, 0));
        vq.push_back(W(A_TGT, 25, 50, 20, 0));
        vq.push_back(W(A_CTL, 32'h07, 50, 20, 0));
        vq.push_back(P(50, 25, 1, 1));
        // Start another ramp that reset will interrupt
        vq.push_back(W(A_TGT, 45, 50, 25, 1));
        vq.push_back(W(A_CTL, 32'h07, 50, 25, 1));
        vq.push_back(R(A_CTL, 32'h1D, 50, 25, 1));
        vq.push_back(P(50, 35, 1, 1));

        // After reset: nothing loads until enabled and a wrap occurs
        vr.push_back(P(0, 0, 0, 0));
        vr.push_back(R(A_CTL, 32'h00, 0, 0, 0));
        vr.push_back(W(A_PER, 20, 0, 0, 0));
        vr.push_back(W(A_CTL, 32'h01, 0, 0, 0));
        vr.push_back(P(20, 0, 1, 0));
        vr.push_back(R(A_CTL, 32'h01, 20, 0, 0));

        RESETN = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0; period_end = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check_all_zero("reset");
        @(negedge CLK);
        RESETN = 1'b1;

        foreach (vq[i]) run_vec(vq[i], i);

        // Asynchronous reset while mid-ramp with load high and rdata nonzero
        sel = 1'b0; we = 1'b0; period_end = 1'b0;
        chk("pre-reset pwm_load", -1, 32'(pwm_load), 32'd1);
        RESETN = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;

        foreach (vr[i]) run_vec(vr[i], 1000 + i);

        @(negedge CLK);
        sel = 1'b0; we = 1'b0; period_end = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_pwm_ramp_ctrl
`default_nettype wire
